// File: rtl/addsub_seq_pkg.sv
// ============================================================================
// addsub_seq_pkg
// Shared definitions for the chunked multi-cycle adder/subtractor:
//   - state_t      : FSM state encoding (IDLE, RUN, DONE)
//   - nchunk()     : number of CHUNK-bit slices in a WIDTH-bit operand
//   - idx_width()  : width of the chunk index counter, clog2(NCHUNK), min 1
//   - DEF_WIDTH / DEF_CHUNK : default geometry used by the top and the bench
// ============================================================================
package addsub_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index so that the
    // counter declaration never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// ============================================================================
// addsub_seq_if
// Request/response bundle of addsub_seq.
//   master : drives start, sub, a, b; observes busy, done, result, cout, ovf
//   slave  : the arithmetic unit side (directions mirrored)
// Parameter WIDTH must match the WIDTH of the connected addsub_seq.
// ============================================================================
interface addsub_seq_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );

endinterface

// File: rtl/addsub_chunk.sv
// ============================================================================
// addsub_chunk
// Combinational CHUNK-bit ripple of full adders.
//   x, y   : CHUNK-bit addends (y already inverted for subtraction)
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1 (needed for signed overflow)
// ============================================================================
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    // NOTE: every variable written in an always_comb block gets a value on
    // every path (here before the loop); a missed path infers a latch.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]  = x[i] ^ y[i] ^ c[i];
            c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// ============================================================================
// addsub_seq
// Multi-cycle two's-complement adder/subtractor. Operands are captured on an
// accepted start and summed CHUNK bits per clock, LSB chunk first, through a
// registered carry using one time-multiplexed addsub_chunk.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : addsub_seq_if.slave (start, sub, a, b -> busy, done, result,
//            cout, ovf); all outputs are driven straight from flops
// Build option: define ADDSUB_SAT_EN to saturate result on signed overflow
// (cout/ovf still report the raw arithmetic).
// WIDTH must be an integer multiple of CHUNK and at least 2.
// ============================================================================
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_seq_if.slave bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NCHUNK - 1);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state_q, state_d;
    idx_t             idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // holds b already xor'ed with sub
    logic [WIDTH-1:0] result_q;
    logic             busy_q, done_q, cout_q, ovf_q;

    logic             accept, last;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum;
    logic             c_out, c_msb;

    // ------------------------------------------------------------------
    // Next-state logic. DONE behaves exactly like IDLE so that a start in
    // the done cycle is accepted back-to-back.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared chunk adder, steered by the chunk index.
    // ------------------------------------------------------------------
    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (a_chunk),
        .y     (b_chunk),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // ------------------------------------------------------------------
    // State and datapath registers. Operand registers are reset along with
    // everything else so that the block comes out of reset fully defined.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent
    // simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);

            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b ^ {WIDTH{bus.sub}};
                carry_q <= bus.sub;         // +1 of a + ~b + 1
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                result_q[idx_q*CHUNK +: CHUNK] <= sum;
                carry_q <= c_out;
                idx_q   <= idx_q + 1'b1;
                if (last) begin
                    cout_q <= c_out;
                    ovf_q  <= c_msb ^ c_out;
`ifdef ADDSUB_SAT_EN
                    // Later assignment overrides the chunk write above.
                    if (c_msb ^ c_out) begin
                        result_q <= a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
                    end
`endif
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle two's-complement adder/subtractor. Operands are captured on a start handshake and processed CHUNK bits per clock, LSB chunk first, through a registered carry. Flags are carry-out and signed overflow. The block is the wide-operand arithmetic unit for datapaths where a single-cycle WIDTH-bit ripple chain would not close timing.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK and at least 2
- CHUNK, 4, bits processed per clock
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- sub  in  1  0 = a+b, 1 = a−b; captured with operands
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result and flags valid
- result  out  WIDTH  sum/difference, held until next accepted start
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed overflow, carry into MSB xor carry out of MSB

## Operation
- NCHUNK = WIDTH/CHUNK.
- Subtraction is a + ~b + 1. b is inverted per bit by sub, and the initial carry equals sub.
- FSM states:
  - IDLE: start=1 captures a, b^{sub}, and sub. It clears the chunk index to 0, loads carry=sub, and moves to RUN.
  - RUN: each cycle, chunk i = index is added using the registered carry. The sum is written into result[i*CHUNK +: CHUNK], carry is updated, and index is incremented. After the chunk with index NCHUNK−1, the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle. The FSM acts as IDLE in this cycle: a start here is accepted, giving back-to-back operation.
- start while busy=1 is ignored. No queuing, no error flag.
- result bits are written only as their chunk completes. Intermediate result values during RUN are undefined to the consumer.
- cout and ovf update only at the final chunk. The final chunk also yields the carry into its MSB for ovf.
- Reset (any time, including mid-RUN): FSM→IDLE, index/carry cleared, busy=0, done=0, result=0, cout=0, ovf=0. An interrupted operation produces no done.

## Timing
- Let E0 be the edge that accepts start. busy=1 from E0 until edge E_NCHUNK.
- At E_NCHUNK, busy falls, done rises for one cycle, and result/cout/ovf become valid.
- Latency is NCHUNK cycles from the accepting edge to the done cycle. Throughput is one operation per NCHUNK cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ADDSUB_SAT_EN defined: when the final ovf=1, result is replaced by the saturation value.
  - a[WIDTH−1]=0 → 0 followed by all ones (max positive).
  - a[WIDTH−1]=1 → 1 followed by all zeros (min negative).
  - ovf and cout still report the raw, unsaturated arithmetic.
- ADDSUB_SAT_EN undefined: result is the raw modulo-2^WIDTH value. No saturation logic is built.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, RUN, DONE)
  - the NCHUNK derivation
  - the index width clog2(NCHUNK)
- One sub-module: addsub_chunk, a combinational CHUNK-bit ripple of full adders. Its outputs are CHUNK-bit sum, carry out, and carry into MSB.
- The top-level instantiates exactly one addsub_chunk, time-multiplexed across chunks.

## Test plan
Defaults WIDTH=16, CHUNK=4.
- Add: start with a=0x1234, b=0x0F0F, sub=0 → done 4 cycles after the accepting edge; result=0x2143, cout=0, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 → result=0xFFFE, cout=0, ovf=0.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0 → ovf=1, cout=0. Without macro: result=0x8000. With ADDSUB_SAT_EN: result=0x7FFF.
- Negative overflow: a=0x8000, b=0x0001, sub=1 → ovf=1, cout=1. Without macro: result=0x7FFF. With ADDSUB_SAT_EN: result=0x8000.
- Handshake:
  - start pulsed at cycle 2 of RUN is ignored; the first operation's result is unchanged.
  - start asserted in the done cycle is accepted, and a second done follows 4 cycles later.
- Reset: rst_n low during RUN → all outputs 0 asynchronously. After release, no done occurs until a new start.
